reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: MAX_INFLIGHT, default 3, max writes outstanding per tracked entry (counter width 2 bits).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 issue_valid  input  1  decode stage presents an instruction for issue into register fetch.
REQ-005 issue_rd  input  4  destination register of issuing instruction.
REQ-006 issue_wr_rd  input  1  issuing instruction writes issue_rd.
REQ-007 issue_wr_cpsr  input  1  issuing instruction writes CPSR flags (S bit).
REQ-008 issue_rn / issue_rm / issue_rs  input  4 each  source register numbers.
REQ-009 issue_use_rn / issue_use_rm / issue_use_rs  input  1 each  source actually read.
REQ-010 issue_use_cpsr  input  1  instruction condition is not AL (reads flags).
REQ-011 wb_valid  input  1  writeback stage retires a register write this cycle.
REQ-012 wb_rd  input  4  register written at writeback.
REQ-013 wb_cpsr  input  1  writeback stage commits CPSR flags this cycle.
REQ-014 flush  input  1  pipeline drained/squashed; clear all tracking.
REQ-015 stall  output  1  combinational; issuing instruction must be held.
REQ-016 busy_mask  output  16  registered; bit n (n=0..14) = r<n> has nonzero count, bit 15 = CPSR nonzero.
REQ-017 underflow_err  output  1  registered sticky error flag.

Function
REQ-018 Tracked entries: r0..r14 and CPSR (index 15); each holds a 2-bit in-flight counter.
REQ-019 r15 (PC) is never tracked; issue_wr_rd with issue_rd=15 has no counter effect; sources equal to 15 never stall.
REQ-020 stall SHALL be 1 when issue_valid=1 and any used source (rn/rm/rs with use flag, excluding 15) has nonzero counter.
REQ-021 stall SHALL be 1 when issue_valid=1, issue_use_cpsr=1 and CPSR counter nonzero.
REQ-022 stall SHALL be 1 when issue_valid=1 and a targeted counter (rd≠15 with issue_wr_rd, or CPSR with issue_wr_cpsr) equals MAX_INFLIGHT.
REQ-023 stall SHALL be 0 whenever issue_valid=0 or flush=1.
REQ-024 Issue accepted in a cycle iff issue_valid=1 and stall=0; accepted issue increments each targeted counter by 1 at the next edge.
REQ-025 Source comparison uses counter values before the current cycle's writeback; same-cycle writeback does not bypass a stall.
REQ-026 wb_valid=1 decrements counter[wb_rd] by 1 at next edge; wb_rd=15 ignored.
REQ-027 wb_cpsr=1 decrements CPSR counter by 1 at next edge.
REQ-028 Accepted issue and writeback to the same entry in one cycle: counter unchanged.
REQ-029 Decrement of a zero counter: counter stays 0, underflow_err set to 1 and held until reset.
REQ-030 flush=1: all counters cleared at next edge; same-cycle issue and writeback ignored; underflow_err not affected.
REQ-031 busy_mask reflects counters after the edge (one-cycle latency from issue/writeback to mask change).

Reset
REQ-032 reset=1 at an edge: all counters 0, busy_mask 0, underflow_err 0; overrides flush, issue and writeback.
REQ-033 During reset cycle stall follows REQ-020..023 from current (pre-reset) counters; issue not recorded.
REQ-034 Reset mid-operation discards all in-flight tracking; no error raised by later writebacks until a zero counter is decremented.

Structure
REQ-035 Shared package holds: register index constants (PC=15, CPSR_IDX=15), counter width, MAX_INFLIGHT default.
REQ-036 One sub-module, sb_counter: single 2-bit saturating up/down counter with inc, dec, clr inputs, value and underflow outputs; instantiated 16 times.

Verification
REQ-037 Issue r3 write, next cycle issue reading rn=r3 -> stall=1; wb_rd=3 -> stall=0 cycle after, busy_mask[3] 1->0.
REQ-038 Issue r5 write three times with no writeback -> counter 3; fourth issue writing r5 -> stall=1; one wb r5 -> fourth accepted, count stays 3.
REQ-039 Same cycle: accepted issue writing r2 and wb_rd=2 with count 1 -> count stays 1, busy_mask[2]=1.
REQ-040 Issue with issue_wr_cpsr, then conditional issue (use_cpsr=1) -> stall=1 until wb_cpsr; reads of r15 never stall.
REQ-041 wb_valid wb_rd=7 with counter 0 -> underflow_err=1 next cycle, persists until reset.
REQ-042 Counters r1=2, CPSR=1, then flush with simultaneous issue r4 -> busy_mask=0 next cycle, r4 not recorded; reset likewise clears.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard.
// Holds the tracked-entry indices, the in-flight counter width, the default write depth
// and a small helper that recognises the PC.
package reg_scoreboard_pkg;

  localparam int unsigned NUM_ENTRIES      = 16;
  localparam int unsigned CNT_W            = 2;
  localparam int unsigned PC_IDX           = 15;
  // CPSR reuses slot 15 because the PC is never tracked.
  localparam int unsigned CPSR_IDX         = 15;
  localparam int unsigned MAX_INFLIGHT_DEF = 3;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [3:0]       reg_idx_t;

  function automatic logic is_pc(input reg_idx_t r);
    return r == reg_idx_t'(PC_IDX);
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/status bundle between the pipeline and the register scoreboard.
//   master : pipeline side, drives issue, writeback and flush; observes stall/status
//   slave  : scoreboard side
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic        issue_valid;
  reg_idx_t    issue_rd;
  logic        issue_wr_rd;
  logic        issue_wr_cpsr;
  reg_idx_t    issue_rn;
  reg_idx_t    issue_rm;
  reg_idx_t    issue_rs;
  logic        issue_use_rn;
  logic        issue_use_rm;
  logic        issue_use_rs;
  logic        issue_use_cpsr;
  logic        wb_valid;
  reg_idx_t    wb_rd;
  logic        wb_cpsr;
  logic        flush;
  logic        stall;
  logic [15:0] busy_mask;
  logic        underflow_err;

  modport master (
    output issue_valid, issue_rd, issue_wr_rd, issue_wr_cpsr,
    output issue_rn, issue_rm, issue_rs, issue_use_rn, issue_use_rm, issue_use_rs,
    output issue_use_cpsr, wb_valid, wb_rd, wb_cpsr, flush,
    input  stall, busy_mask, underflow_err
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wr_rd, issue_wr_cpsr,
    input  issue_rn, issue_rm, issue_rs, issue_use_rn, issue_use_rm, issue_use_rs,
    input  issue_use_cpsr, wb_valid, wb_rd, wb_cpsr, flush,
    output stall, busy_mask, underflow_err
  );

endinterface

// File: rtl/sb_counter.sv
// One in-flight write counter for a scoreboard entry.
//   clk       : clock
//   clr       : synchronous clear (reset or flush), wins over inc/dec
//   inc, dec  : count up / down; both together leave the count unchanged
//   value     : current count
//   underflow : combinational, dec of a zero count this cycle (count stays 0)
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output cnt_t value,
  output logic underflow
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != '1) cnt_d = cnt_q + cnt_t'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) underflow = 1'b1;
      else             cnt_d     = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register/CPSR hazard scoreboard between decode and register fetch.
// Tracks outstanding writes to r0..r14 and CPSR and stalls issue on RAW hazards or when a
// destination already has MAX_INFLIGHT writes pending.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of reg_scoreboard_if (issue, writeback, flush, stall, status)
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input logic              clk,
  input logic              reset,
  reg_scoreboard_if.slave  bus
);

  localparam cnt_t MaxCnt = cnt_t'(MAX_INFLIGHT);

  cnt_t                   cnt [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] inc, dec, udf;
  logic                   src_busy, cpsr_busy, tgt_full, stall_c, accept, clr;
  logic                   err_q;

  // Hazard checks use the counters as they stand, so a same-cycle writeback never bypasses.
  always_comb begin
    src_busy  = (bus.issue_use_rn && !is_pc(bus.issue_rn) && cnt[bus.issue_rn] != '0) ||
                (bus.issue_use_rm && !is_pc(bus.issue_rm) && cnt[bus.issue_rm] != '0) ||
                (bus.issue_use_rs && !is_pc(bus.issue_rs) && cnt[bus.issue_rs] != '0);
    cpsr_busy = bus.issue_use_cpsr && cnt[CPSR_IDX] != '0;
    tgt_full  = (bus.issue_wr_rd && !is_pc(bus.issue_rd) && cnt[bus.issue_rd] == MaxCnt) ||
                (bus.issue_wr_cpsr && cnt[CPSR_IDX] == MaxCnt);
    stall_c   = bus.issue_valid && !bus.flush && (src_busy || cpsr_busy || tgt_full);
  end

  assign accept = bus.issue_valid && !stall_c;
  assign clr    = reset || bus.flush;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < int'(PC_IDX); i++) begin
      inc[i] = accept && bus.issue_wr_rd && (bus.issue_rd == reg_idx_t'(i));
      dec[i] = bus.wb_valid && (bus.wb_rd == reg_idx_t'(i));
    end
    inc[CPSR_IDX] = accept && bus.issue_wr_cpsr;
    dec[CPSR_IDX] = bus.wb_cpsr;
  end

  for (genvar g = 0; g < int'(NUM_ENTRIES); g++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .clr       (clr),
      .inc       (inc[g]),
      .dec       (dec[g]),
      .value     (cnt[g]),
      .underflow (udf[g])
    );
  end

  // Sticky: only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (reset)     err_q <= 1'b0;
    else if (|udf) err_q <= 1'b1;
  end

  always_comb begin
    bus.busy_mask = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) bus.busy_mask[i] = (cnt[i] != '0);
  end

  assign bus.stall         = stall_c;
  assign bus.underflow_err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.MAX_INFLIGHT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb_if)
  );

  typedef struct {
    logic       iv;
    logic [3:0] rd;
    logic       wr_rd;
    logic       wr_cpsr;
    logic [3:0] rn;
    logic       use_rn;
    logic       use_cpsr;
    logic       wbv;
    logic [3:0] wbrd;
    logic       wbc;
    logic       fl;
    logic       rst;
    logic       exp_stall;
    logic [15:0] exp_mask;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: in-flight writes per entry (15 = CPSR) and the sticky error.
  int m_cnt [16];
  bit m_err;

  function automatic vec_t mk(logic iv, logic [3:0] rd, logic wr_rd, logic wr_cpsr,
                              logic [3:0] rn, logic use_rn, logic use_cpsr, logic wbv,
                              logic [3:0] wbrd, logic wbc, logic fl, logic rst,
                              logic es, logic [15:0] em, logic ee);
    vec_t v;
    v.iv = iv; v.rd = rd; v.wr_rd = wr_rd; v.wr_cpsr = wr_cpsr; v.rn = rn;
    v.use_rn = use_rn; v.use_cpsr = use_cpsr; v.wbv = wbv; v.wbrd = wbrd; v.wbc = wbc;
    v.fl = fl; v.rst = rst; v.exp_stall = es; v.exp_mask = em; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] rd, input logic wr_rd,
                       input logic wr_cpsr, input logic [3:0] rn, input logic [3:0] rm,
                       input logic [3:0] rs, input logic urn, input logic urm,
                       input logic urs, input logic uc, input logic wbv,
                       input logic [3:0] wbrd, input logic wbc, input logic fl,
                       input logic rst);
    sb_if.issue_valid    = iv;
    sb_if.issue_rd       = rd;
    sb_if.issue_wr_rd    = wr_rd;
    sb_if.issue_wr_cpsr  = wr_cpsr;
    sb_if.issue_rn       = rn;
    sb_if.issue_rm       = rm;
    sb_if.issue_rs       = rs;
    sb_if.issue_use_rn   = urn;
    sb_if.issue_use_rm   = urm;
    sb_if.issue_use_rs   = urs;
    sb_if.issue_use_cpsr = uc;
    sb_if.wb_valid       = wbv;
    sb_if.wb_rd          = wbrd;
    sb_if.wb_cpsr        = wbc;
    sb_if.flush          = fl;
    reset                = rst;
  endtask

  function automatic logic [3:0] pick_reg();
    if ($urandom_range(0, 6) == 0) return 4'd15;
    return 4'($urandom_range(0, 4));
  endfunction

  function automatic bit src_hazard(logic use_it, logic [3:0] r);
    return use_it && (r != 4'd15) && (m_cnt[r] != 0);
  endfunction

  initial begin
    // Directed table: starts from an empty scoreboard, each row one cycle.
    //               iv rd    wr wc rn    un uc wb wbrd  wc fl rs   stall mask     err
    vecs.push_back(mk(1, 4'd3, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0008, 0));
    vecs.push_back(mk(1, 4'd0, 0, 0, 4'd3, 1, 0, 0, 4'd0, 0, 0, 0,  1, 16'h0008, 0));
    vecs.push_back(mk(1, 4'd0, 0, 0, 4'd3, 1, 0, 1, 4'd3, 0, 0, 0,  1, 16'h0000, 0));
    vecs.push_back(mk(1, 4'd0, 0, 0, 4'd3, 1, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0000, 0));
    vecs.push_back(mk(1, 4'd5, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0020, 0));
    vecs.push_back(mk(1, 4'd5, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0020, 0));
    vecs.push_back(mk(1, 4'd5, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0020, 0));
    vecs.push_back(mk(1, 4'd5, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  1, 16'h0020, 0));
    vecs.push_back(mk(1, 4'd5, 1, 0, 4'd0, 0, 0, 1, 4'd5, 0, 0, 0,  1, 16'h0020, 0));
    vecs.push_back(mk(1, 4'd5, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0020, 0));
    vecs.push_back(mk(1, 4'd5, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  1, 16'h0020, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 4'd5, 0, 0, 0,  0, 16'h0020, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 4'd5, 0, 0, 0,  0, 16'h0020, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 4'd5, 0, 0, 0,  0, 16'h0000, 0));
    vecs.push_back(mk(1, 4'd2, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0004, 0));
    vecs.push_back(mk(1, 4'd2, 1, 0, 4'd0, 0, 0, 1, 4'd2, 0, 0, 0,  0, 16'h0004, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 4'd2, 0, 0, 0,  0, 16'h0000, 0));
    vecs.push_back(mk(1, 4'd0, 0, 1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h8000, 0));
    vecs.push_back(mk(1, 4'd0, 0, 0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 0,  1, 16'h8000, 0));
    vecs.push_back(mk(1, 4'd0, 0, 0, 4'd15,1, 1, 0, 4'd0, 0, 0, 0,  1, 16'h8000, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 0,  0, 16'h0000, 0));
    vecs.push_back(mk(1, 4'd15,1, 0, 4'd15,1, 1, 0, 4'd0, 0, 0, 0,  0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 4'd7, 0, 0, 0,  0, 16'h0000, 1));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0000, 1));
    vecs.push_back(mk(1, 4'd1, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0002, 1));
    vecs.push_back(mk(1, 4'd1, 1, 1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h8002, 1));
    vecs.push_back(mk(1, 4'd4, 1, 0, 4'd1, 1, 0, 1, 4'd1, 0, 1, 0,  0, 16'h0000, 1));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0000, 1));
    vecs.push_back(mk(1, 4'd1, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 16'h0002, 1));
    vecs.push_back(mk(1, 4'd4, 1, 0, 4'd1, 1, 0, 0, 4'd0, 0, 0, 1,  1, 16'h0000, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 4'd1, 0, 0, 0,  0, 16'h0000, 1));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1,  0, 16'h0000, 0));

    // Reset state.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset busy_mask", sb_if.busy_mask, 16'h0000);
    chk("reset underflow_err", {15'b0, sb_if.underflow_err}, 16'h0000);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].rd, vecs[i].wr_rd, vecs[i].wr_cpsr, vecs[i].rn, 4'd0, 4'd0,
            vecs[i].use_rn, 1'b0, 1'b0, vecs[i].use_cpsr, vecs[i].wbv, vecs[i].wbrd,
            vecs[i].wbc, vecs[i].fl, vecs[i].rst);
      #4;
      chk($sformatf("vec%0d stall", i), {15'b0, sb_if.stall}, {15'b0, vecs[i].exp_stall});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d busy_mask", i), sb_if.busy_mask, vecs[i].exp_mask);
      chk($sformatf("vec%0d underflow_err", i), {15'b0, sb_if.underflow_err},
          {15'b0, vecs[i].exp_err});
    end

    // Randomized run against the reference model, starting from a reset.
    for (int e = 0; e < 16; e++) m_cnt[e] = 0;
    m_err = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic       iv, wr_rd, wr_cpsr, urn, urm, urs, uc, wbv, wbc, fl, rst;
      logic [3:0] rd, rn, rm, rs, wbrd;
      bit         exp_stall, acc;
      logic [15:0] exp_mask;
      iv      = ($urandom_range(0, 3) != 0);
      rd      = pick_reg();
      wr_rd   = $urandom_range(0, 1) == 1;
      wr_cpsr = $urandom_range(0, 3) == 0;
      rn = pick_reg(); rm = pick_reg(); rs = pick_reg();
      urn = $urandom_range(0, 2) == 0;
      urm = $urandom_range(0, 3) == 0;
      urs = $urandom_range(0, 5) == 0;
      uc  = $urandom_range(0, 4) == 0;
      wbv = $urandom_range(0, 2) == 0;
      wbrd = pick_reg();
      wbc = $urandom_range(0, 5) == 0;
      fl  = $urandom_range(0, 39) == 0;
      rst = (cyc == 0) || ($urandom_range(0, 49) == 0);
      drive(iv, rd, wr_rd, wr_cpsr, rn, rm, rs, urn, urm, urs, uc, wbv, wbrd, wbc, fl, rst);

      exp_stall = iv && !fl &&
                  (src_hazard(urn, rn) || src_hazard(urm, rm) || src_hazard(urs, rs) ||
                   (uc && m_cnt[15] != 0) ||
                   (wr_rd && rd != 4'd15 && m_cnt[rd] == 3) ||
                   (wr_cpsr && m_cnt[15] == 3));
      acc = iv && !exp_stall;
      #4;
      chk($sformatf("rand%0d stall", cyc), {15'b0, sb_if.stall}, {15'b0, exp_stall});

      if (rst || fl) begin
        for (int e = 0; e < 16; e++) m_cnt[e] = 0;
        if (rst) m_err = 0;
      end else begin
        for (int e = 0; e < 16; e++) begin
          int nc;
          nc = m_cnt[e];
          if (acc && ((e < 15 && wr_rd && rd == 4'(e)) || (e == 15 && wr_cpsr))) nc++;
          if ((e < 15 && wbv && wbrd == 4'(e)) || (e == 15 && wbc)) nc--;
          if (nc < 0) begin
            nc = 0;
            m_err = 1;
          end
          m_cnt[e] = nc;
        end
      end
      for (int e = 0; e < 16; e++) exp_mask[e] = (m_cnt[e] != 0);

      @(posedge clk);
      #1;
      chk($sformatf("rand%0d busy_mask", cyc), sb_if.busy_mask, exp_mask);
      chk($sformatf("rand%0d underflow_err", cyc), {15'b0, sb_if.underflow_err},
          {15'b0, m_err});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
